// File: rtl/uart_frame_pkg.sv
// Shared frame definitions for the even-parity UART transmitter and its receiver-side peers.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int   DATA_BITS   = 8;
  localparam int   FRAME_BITS  = 11;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/even_parity_gen.sv
// Combinational even-parity bit for one byte; the receiver reuses it to check frames.
module even_parity_gen
  import uart_frame_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = ^data;

endmodule

// File: rtl/even_parity_uart_tx.sv
// Start / 8 data LSB-first / even parity / stop serializer with a valid/ready byte input.
module even_parity_uart_tx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 parity_out,
  output state_e               state_dbg
);

  // Handshake: a byte moves on a rising edge where valid && ready; ready is high only in IDLE.
  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   parity_q, parity_d;
  logic                   byte_parity;
  logic                   bit_end;

  even_parity_gen u_parity (
    .data   (data_in),
    .parity (byte_parity)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? '0 : baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (valid && ready_q) begin
          state_d   = START;
          shift_d   = data_in;
          parity_d  = byte_parity;
          bit_idx_d = '0;
          tx_d      = START_LEVEL;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        // tx is registered, so the next bit is taken from shift_q[1] as the register shifts.
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = STOP_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      parity_q  <= parity_d;
    end
  end

  assign ready      = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign parity_out = parity_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_even_parity_uart_tx.sv
// Bench for even_parity_uart_tx: frame-position model, tx-line receiver and byte scoreboard.
module tb_even_parity_uart_tx;
  import uart_frame_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 11 * CPB;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, tx, busy, parity_out;
  state_e     state_dbg;

  always #5 clk = ~clk;

  even_parity_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid      (valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .parity_out (parity_out),
    .state_dbg  (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: position inside the 11-bit frame, -1 when the line is idle
  int         cyc = 0;
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic       m_par = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pos = -1;
      m_par = 1'b0;
    end else if (m_pos < 0) begin
      if (valid) begin
        m_pos  = 0;
        m_byte = data_in;
        m_par  = ^data_in;
      end
    end else begin
      m_pos++;
      if (m_pos == FRAME_CYC) begin
        m_pos = -1;
        exp_q.push_back(m_byte);
      end
    end
  end

  function automatic logic model_tx();
    logic [10:0] frame;
    if (m_pos < 0) return 1'b1;
    frame = {1'b1, m_par, m_byte, 1'b0};
    return frame[m_pos / CPB];
  endfunction

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("tx", tx, model_tx());
      check("ready", ready, m_pos < 0);
      check("busy", busy, m_pos >= 0);
      check("parity_out", parity_out, m_par);
    end
  end

  // receiver on the tx line, sampling each bit on its second cycle
  int          rx_pos = -1;
  logic        prev_tx = 1'b1;
  logic [10:0] rx_bits = '0;
  logic [10:0] last_frame = '0;
  logic [7:0]  rx_q[$];
  logic        par_q[$];
  int          start_cyc_q[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rx_pos < 0) begin
        if (tx === 1'b0 && prev_tx === 1'b1) begin
          rx_pos = 0;
          start_cyc_q.push_back(cyc);
        end
      end else if (m_pos < 0) begin
        rx_pos = -1;
      end
      if (rx_pos >= 0) begin
        if (rx_pos % CPB == 1) rx_bits[rx_pos / CPB] = tx;
        if (rx_pos == 10 * CPB + 1) begin
          last_frame = rx_bits;
          rx_q.push_back(rx_bits[8:1]);
          par_q.push_back(rx_bits[9]);
          check("frame_even_ones", ^rx_bits[9:1], 1'b0);
          check("stop_bit", rx_bits[10], 1'b1);
          rx_pos = -1;
        end else begin
          rx_pos++;
        end
      end
      prev_tx = tx;
    end
  end

  // driver tasks
  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready === 1'b1) return;
    end
    check("wait_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    valid   = 1'b1;
    data_in = b;
    @(negedge clk);
    valid   = 1'b0;
    data_in = 8'($urandom);
  endtask

  initial begin
    int d;
    logic [7:0] b;
    logic       seen_ff;

    // reset with valid and 8'hFF presented
    rst = 1'b1; valid = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_parity", parity_out, 1'b0);
    end
    rst = 1'b0; valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_frame", start_cyc_q.size(), 0);

    // single byte 8'h03
    send(8'h03);
    wait_ready();
    check("h03_frame", last_frame, 11'b10_0000_0011_0);
    check("h03_parity", parity_out, 1'b0);

    // single byte 8'h01
    send(8'h01);
    wait_ready();
    check("h01_parity_bit", last_frame[9], 1'b1);
    check("h01_ones9", $countones(last_frame[9:1]), 2);
    check("h01_parity_out", parity_out, 1'b1);

    // back-to-back 8'hDB, 8'h1C with valid held high
    wait_ready();
    valid = 1'b1; data_in = 8'hDB;
    @(negedge clk);
    data_in = 8'h1C;
    wait_ready();
    @(negedge clk);
    valid = 1'b0;
    wait_ready();
    d = start_cyc_q[start_cyc_q.size()-1] - start_cyc_q[start_cyc_q.size()-2];
    check("b2b_start_gap", d, 45);
    check("b2b_db_parity", par_q[par_q.size()-2], 1'b0);
    check("b2b_1c_parity", par_q[par_q.size()-1], 1'b1);
    check("b2b_db_byte", rx_q[rx_q.size()-2], 8'hDB);
    check("b2b_1c_byte", rx_q[rx_q.size()-1], 8'h1C);

    // valid with 8'hFF while the 8'h55 frame is busy
    send(8'h55);
    repeat (5) @(negedge clk);
    valid = 1'b1; data_in = 8'hFF;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    wait_ready();
    check("busy_55_byte", last_frame[8:1], 8'h55);
    check("busy_55_parity", last_frame[9], 1'b0);
    seen_ff = 1'b0;
    foreach (rx_q[i]) if (rx_q[i] == 8'hFF) seen_ff = 1'b1;
    check("busy_ff_dropped", seen_ff, 1'b0);

    // reset during data bit 3 of 8'hAA, then a clean 8'h55
    send(8'hAA);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_ready", ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    send(8'h55);
    wait_ready();
    check("after_rst_55_frame", last_frame, 11'b10_0101_0101_0);

    // random traffic with ignored valid pulses while busy
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(b);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        valid = 1'b1; data_in = 8'($urandom);
        repeat ($urandom_range(1, 10)) @(negedge clk);
        valid = 1'b0;
      end
      wait_ready();
    end
    repeat (3) @(negedge clk);

    // final report: scoreboard drain
    check("scoreboard_count", rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check("scoreboard_byte", rx_q.pop_front(), exp_q.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
